// File: rtl/audio_pkg.sv
// Shared types and helpers for the record/playback sequencer and its codec-side timing.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int PROG_W   = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic int calc_div(input int clk_hz, input int sample_rate);
      return clk_hz / sample_rate;
   endfunction

   function automatic int calc_total(input int sample_rate, input int record_time);
      return sample_rate * record_time;
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and flags the last count; clr_i restarts the count.
module sample_tick_gen #(
   parameter int DIV = 1041
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/audio_buffer_ctrl.sv
// Record/playback sequencer owning the single-port sample RAM.
// States: IDLE passthrough | RECORD write on tick | PLAY read on tick | DONE one-cycle settle
module audio_buffer_ctrl
   import audio_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int SAMPLE_RATE = 48000,
   parameter int RECORD_TIME = 2,
   parameter int ADDR_W      = 17
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_rec_n,
   input  logic                key_play_n,
   input  logic [SAMPLE_W-1:0] mic_in,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_we,
   output logic [SAMPLE_W-1:0] ram_wdata,
   input  logic [SAMPLE_W-1:0] ram_rdata,
   output logic [SAMPLE_W-1:0] audio_out,
   output logic [17:0]         ledr,
   output logic                busy
);

   localparam int DIV   = calc_div(CLK_HZ, SAMPLE_RATE);
   localparam int TOTAL = calc_total(SAMPLE_RATE, RECORD_TIME);
   localparam int LEN_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [LEN_W-1:0]  TOTAL_LEN = LEN_W'(TOTAL);

   logic [1:0] rec_sync_q, play_sync_q;
   logic       rec_prev_q, play_prev_q;
   logic       rec_press, play_press;

   state_e                state_q, state_d;
   logic                  tick, div_clr;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [LEN_W-1:0]      rec_len_q, rec_len_d;
   logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
   logic                  ram_we_q, ram_we_d;
   logic [SAMPLE_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [SAMPLE_W-1:0]   audio_q, audio_d;
   logic [1:0]            rd_pipe_q, rd_pipe_d;
   logic                  last_rd;

   // Keys idle high, so the synchronisers reset to 1 to avoid a phantom press.
   assign rec_press  = rec_prev_q  & ~rec_sync_q[1];
   assign play_press = play_prev_q & ~play_sync_q[1];

   assign div_clr = (state_d != state_q);
   assign last_rd = ({1'b0, ram_addr_q} == (rec_len_q - 1'b1));

   sample_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (div_clr),
      .tick_o (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rec_sync_q  <= 2'b11;
         play_sync_q <= 2'b11;
         rec_prev_q  <= 1'b1;
         play_prev_q <= 1'b1;
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rec_len_q   <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         audio_q     <= '0;
         rd_pipe_q   <= '0;
      end else begin
         rec_sync_q  <= {rec_sync_q[0], key_rec_n};
         play_sync_q <= {play_sync_q[0], key_play_n};
         rec_prev_q  <= rec_sync_q[1];
         play_prev_q <= play_sync_q[1];
         state_q     <= state_d;
         addr_q      <= addr_d;
         rec_len_q   <= rec_len_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         audio_q     <= audio_d;
         rd_pipe_q   <= rd_pipe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rec_press)                          state_d = ST_RECORD;
            else if (play_press && rec_len_q != '0) state_d = ST_PLAY;
         end
         ST_RECORD: begin
            if ((tick && addr_q == LAST_ADDR) || rec_press) state_d = ST_DONE;
         end
         ST_PLAY: begin
            if (play_press)                  state_d = ST_IDLE;
            else if (rd_pipe_q[1] && last_rd) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      rec_len_d   = rec_len_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      audio_d     = audio_q;
      rd_pipe_d   = '0;
      case (state_q)
         ST_IDLE: begin
            audio_d = mic_in;
            addr_d  = '0;
         end
         ST_RECORD: begin
            audio_d = mic_in;
            if (tick) begin
               ram_we_d    = 1'b1;
               ram_wdata_d = mic_in;
               ram_addr_d  = addr_q;
               addr_d      = addr_q + 1'b1;
            end
            // A stop press on a tick cycle still counts the sample being written.
            if (tick && addr_q == LAST_ADDR) rec_len_d = TOTAL_LEN;
            else if (rec_press)              rec_len_d = LEN_W'({1'b0, addr_q}) + LEN_W'(tick);
         end
         ST_PLAY: begin
            rd_pipe_d = {rd_pipe_q[0], tick};
            if (tick) begin
               ram_addr_d = addr_q;
               addr_d     = addr_q + 1'b1;
            end
            if (rd_pipe_q[1]) audio_d = ram_rdata;
         end
         default: ;
      endcase
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign audio_out = audio_q;
   assign ledr[0]    = (state_q == ST_RECORD);
   assign ledr[1]    = (state_q == ST_PLAY);
   assign ledr[16:2] = addr_q[ADDR_W-1 -: PROG_W];
   assign ledr[17]   = (rec_len_q != '0);
   assign busy       = ledr[0] | ledr[1];

endmodule

// File: tb/tb_audio_buffer_ctrl.sv
// Scoreboard bench for audio_buffer_ctrl with a behavioural sync-read sample RAM.
module tb_audio_buffer_ctrl;

   localparam int ADDR_W = 17;
   localparam int DIV    = 10;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              key_rec_n = 1'b1;
   logic              key_play_n = 1'b1;
   logic [15:0]       mic_in = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [15:0]       ram_wdata;
   logic [15:0]       ram_rdata = '0;
   logic [15:0]       audio_out;
   logic [17:0]       ledr;
   logic              busy;

   logic [15:0] mem [0:31];

   ent_t wq[$];
   ent_t pq[$];

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          nwr = 0;
   int          ncap = 0;
   int          last_wr = -1;
   bit          ramp = 1'b0;
   bit          prev_ledr1 = 1'b0;
   logic [15:0] prev_audio = '0;
   logic [15:0] last_mic;

   audio_buffer_ctrl #(
      .CLK_HZ      (100),
      .SAMPLE_RATE (10),
      .RECORD_TIME (1),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_rec_n  (key_rec_n),
      .key_play_n (key_play_n),
      .mic_in     (mic_in),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .audio_out  (audio_out),
      .ledr       (ledr),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[4:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[4:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock, then check any write strobe or play capture against the queues.
   task automatic step();
      ent_t e;
      @(negedge clk);
      cyc++;
      if (ram_we) begin
         nwr++;
         if (wq.size() == 0) chk("wr_expected", 32'(ram_addr), 32'hFFFF_FFFF);
         else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(e.addr));
            chk("wr_data", 32'(ram_wdata), 32'(e.data));
         end
         if (last_wr >= 0) chk("wr_spacing", 32'(cyc - last_wr), 32'(DIV));
         last_wr = cyc;
         if (ramp) begin
            mic_in = mic_in + 16'd1;
            wq.push_back('{addr: ADDR_W'(nwr), data: mic_in});
         end
      end
      if ((ledr[1] || prev_ledr1) && audio_out !== prev_audio) begin
         ncap++;
         if (pq.size() == 0) chk("rd_expected", 32'(audio_out), 32'hFFFF_FFFF);
         else begin
            e = pq.pop_front();
            chk("rd_data", 32'(audio_out), 32'(e.data));
            chk("rd_addr", 32'(ram_addr), 32'(e.addr));
         end
      end
      prev_audio = audio_out;
      prev_ledr1 = ledr[1];
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return busy == 1'b0;
         1:       return nwr >= 4;
         default: return ledr[1] && ram_addr == ADDR_W'(5);
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, input string tag);
      int n = 0;
      while (!cond(sel) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(cond(sel)), 32'd1);
   endtask

   task automatic press(input bit r, input bit p);
      key_rec_n  = ~r;
      key_play_n = ~p;
      repeat (3) step();
      key_rec_n  = 1'b1;
      key_play_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      prev_audio = audio_out;
      prev_ledr1 = 1'b0;
      wq.delete();
      pq.delete();
   endtask

   task automatic record_take(input int stop_after);
      wq.delete();
      nwr = 0;
      last_wr = -1;
      ramp = 1'b1;
      mic_in = 16'h0100;
      wq.push_back('{addr: '0, data: 16'h0100});
      press(1'b1, 1'b0);
      chk("rec_busy", 32'(ledr[0]), 32'd1);
      if (stop_after > 0) begin
         wait_for(1, 100, "rec_nwr_wait");
         press(1'b1, 1'b0);
      end
      wait_for(0, 300, "rec_end");
      ramp = 1'b0;
   endtask

   task automatic play_take(input int n);
      mic_in = 16'h5A5A;
      repeat (2) step();
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back('{addr: ADDR_W'(i), data: 16'h0100 + 16'(i)});
      ncap = 0;
      press(1'b0, 1'b1);
      chk("play_busy", 32'(ledr[1]), 32'd1);
      wait_for(0, 300, "play_end");
      repeat (2) step();
      chk("play_count", 32'(ncap), 32'(n));
      chk("play_left", 32'(pq.size()), 32'd0);
      chk("pass_back", 32'(audio_out), 32'h5A5A);
   endtask

   initial begin
      #1 rst = 1'b1;
      mic_in = 16'(($urandom));
      repeat (3) step();
      chk("rst_audio", 32'(audio_out), 32'd0);
      chk("rst_ledr", 32'(ledr), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      release_reset();
      last_mic = mic_in;

      // Idle passthrough with random samples.
      for (int i = 0; i < 50; i++) begin
         step();
         chk("idle_pass", 32'(audio_out), 32'(last_mic));
         chk("idle_we", 32'(ram_we), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_ledr", 32'(ledr), 32'd0);
         mic_in = 16'($urandom_range(0, 65535));
         last_mic = mic_in;
      end

      // Full take then full playback.
      record_take(0);
      chk("full_nwr", 32'(nwr), 32'd10);
      chk("full_len_led", 32'(ledr[17]), 32'd1);
      play_take(10);
      chk("len_kept", 32'(ledr[17]), 32'd1);

      // Early stop after the fourth write.
      record_take(4);
      chk("short_nwr", 32'(nwr), 32'd4);
      chk("short_len_led", 32'(ledr[17]), 32'd1);
      play_take(4);

      // Play with nothing recorded, then simultaneous presses.
      @(negedge clk) rst = 1'b1;
      step();
      release_reset();
      chk("empty_len", 32'(ledr[17]), 32'd0);
      press(1'b0, 1'b1);
      repeat (10) step();
      chk("empty_play", 32'(busy), 32'd0);
      nwr = 0;
      press(1'b1, 1'b1);
      chk("both_rec", 32'(ledr[0]), 32'd1);
      chk("both_noplay", 32'(ledr[1]), 32'd0);
      press(1'b1, 1'b0);
      wait_for(0, 20, "zero_stop");
      chk("zero_nwr", 32'(nwr), 32'd0);
      chk("zero_len", 32'(ledr[17]), 32'd0);

      // Reset in the middle of playback.
      record_take(0);
      chk("t6_nwr", 32'(nwr), 32'd10);
      mic_in = 16'h5A5A;
      repeat (2) step();
      pq.delete();
      for (int i = 0; i < 10; i++) pq.push_back('{addr: ADDR_W'(i), data: 16'h0100 + 16'(i)});
      ncap = 0;
      press(1'b0, 1'b1);
      wait_for(2, 200, "play_addr5");
      chk("pre_rst_caps", 32'(ncap), 32'd5);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ledr", 32'(ledr), 32'd0);
      chk("mid_rst_audio", 32'(audio_out), 32'd0);
      chk("mid_rst_addr", 32'(ram_addr), 32'd0);
      release_reset();
      press(1'b0, 1'b1);
      repeat (20) step();
      chk("post_rst_play", 32'(busy), 32'd0);
      chk("post_rst_len", 32'(ledr[17]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
